// File: rtl/fp_widen_if.sv
// Handshake bundle for fp_widen: operand in (valid/ready) and result out (valid/ready).
// The slave modport is the converter side; the master modport is the producer/consumer side.
interface fp_widen_if #(
    parameter int IN_EXP  = 8,
    parameter int IN_MAN  = 23,
    parameter int OUT_EXP = 11,
    parameter int OUT_MAN = 52
);
    logic                       in_valid;
    logic                       in_ready;
    logic [IN_EXP+IN_MAN:0]     in_a;
    logic                       out_valid;
    logic                       out_ready;
    logic [OUT_EXP+OUT_MAN:0]   out_z;
    logic                       out_invalid;

    modport master (
        output in_valid, in_a, out_ready,
        input  in_ready, out_valid, out_z, out_invalid
    );

    modport slave (
        input  in_valid, in_a, out_ready,
        output in_ready, out_valid, out_z, out_invalid
    );
endinterface

// File: rtl/fp_widen.sv
// IEEE-754 widening converter (default single -> double) with valid/ready handshake and NaN quieting.
// Define FP_WIDEN_FAST_NORM_EN for single-edge denormal normalisation; default is one shift per edge.
module fp_widen #(
    parameter int IN_EXP  = 8,
    parameter int IN_MAN  = 23,
    parameter int OUT_EXP = 11,
    parameter int OUT_MAN = 52
) (
    input logic        clk,
    input logic        rst,
    fp_widen_if.slave  bus
);
    localparam int IN_W     = 1 + IN_EXP + IN_MAN;
    localparam int OUT_W    = 1 + OUT_EXP + OUT_MAN;
    localparam int BIAS_IN  = (1 << (IN_EXP - 1)) - 1;
    localparam int BIAS_OUT = (1 << (OUT_EXP - 1)) - 1;
    localparam int DELTA    = BIAS_OUT - BIAS_IN;
    localparam int PAD      = OUT_MAN - IN_MAN;
    localparam logic [OUT_EXP-1:0] DELTA_E  = OUT_EXP'(DELTA);
    localparam logic [OUT_EXP-1:0] DELTA_P1 = OUT_EXP'(DELTA + 1);

    typedef enum logic [1:0] {S_IDLE, S_CVT, S_NORM, S_OUT} state_t;

    state_t               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_W-1:0]     out_z_q, out_z_d;
    logic                 out_inv_q, out_inv_d;
    logic [IN_W-1:0]      a_q, a_d;
    logic [OUT_MAN:0]     m_q, m_d;
    logic [OUT_EXP-1:0]   e_q, e_d;

    logic                 a_sign;
    logic [IN_EXP-1:0]    a_exp;
    logic [IN_MAN-1:0]    a_frac;
    logic [OUT_MAN-1:0]   frac_ext;
    logic [OUT_MAN-1:0]   nan_frac;

    assign a_sign   = a_q[IN_W-1];
    assign a_exp    = a_q[IN_MAN +: IN_EXP];
    assign a_frac   = a_q[IN_MAN-1:0];
    assign frac_ext = OUT_MAN'(a_frac) << PAD;

    assign bus.in_ready    = (state_q == S_IDLE) && !rst;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_z       = out_z_q;
    assign bus.out_invalid = out_inv_q;

`ifdef FP_WIDEN_FAST_NORM_EN
    function automatic int unsigned lzc(input logic [IN_MAN-1:0] v);
        lzc = IN_MAN;
        for (int i = 0; i < IN_MAN; i++) begin
            if (v[i]) lzc = IN_MAN - 1 - i;
        end
    endfunction

    int unsigned       shift;
    logic [OUT_MAN:0]  m_shift;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_z_d     = out_z_q;
        out_inv_d   = out_inv_q;
        a_d         = a_q;
        m_d         = m_q;
        e_d         = e_q;
        nan_frac    = frac_ext;
        nan_frac[OUT_MAN-1] = 1'b1;
`ifdef FP_WIDEN_FAST_NORM_EN
        shift   = lzc(m_q[OUT_MAN-1 -: IN_MAN]) + 1;
        m_shift = m_q << shift;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    state_d = S_CVT;
                end
            end
            S_CVT: begin
                out_inv_d = 1'b0;
                state_d   = S_OUT;
                out_valid_d = 1'b1;
                if (a_exp == '0) begin
                    if (a_frac == '0) begin
                        out_z_d = {a_sign, {OUT_EXP{1'b0}}, {OUT_MAN{1'b0}}};
                    end else begin
                        // Denormal: the hidden bit sits one above the fraction and is found by shifting.
                        m_d         = {1'b0, frac_ext};
                        e_d         = DELTA_P1;
                        state_d     = S_NORM;
                        out_valid_d = 1'b0;
                    end
                end else if (a_exp == '1) begin
                    if (a_frac == '0) begin
                        out_z_d = {a_sign, {OUT_EXP{1'b1}}, {OUT_MAN{1'b0}}};
                    end else begin
                        out_z_d   = {a_sign, {OUT_EXP{1'b1}}, nan_frac};
                        out_inv_d = ~a_frac[IN_MAN-1];
                    end
                end else begin
                    out_z_d = {a_sign, OUT_EXP'(a_exp) + DELTA_E, frac_ext};
                end
            end
            S_NORM: begin
`ifdef FP_WIDEN_FAST_NORM_EN
                out_z_d     = {a_sign, e_q - OUT_EXP'(shift), m_shift[OUT_MAN-1:0]};
                out_valid_d = 1'b1;
                state_d     = S_OUT;
`else
                if (m_q[OUT_MAN]) begin
                    out_z_d     = {a_sign, e_q, m_q[OUT_MAN-1:0]};
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_inv_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_inv_q   <= out_inv_d;
        end
    end

    // NOTE: operand and normaliser registers are not reset; they are only read in states entered after a load.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        m_q <= m_d;
        e_q <= e_d;
    end
endmodule

// File: tb/tb_fp_widen.sv
// Directed-vector bench for fp_widen (single -> double) with hand-computed results and latencies.
module tb_fp_widen;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fp_widen_if bus ();

    fp_widen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FP_WIDEN_FAST_NORM_EN
    localparam int LAT_DEN_MIN = 2;
    localparam int LAT_DEN_MAX = 2;
`else
    localparam int LAT_DEN_MIN = 25;
    localparam int LAT_DEN_MAX = 3;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accept one operand with out_ready high, measure edges to out_valid, check result, complete handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [63:0] z_exp,
                          input logic inv_exp, input int lat_exp);
        int lat;
        bit seen;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 64) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        check({tag, "_z"}, bus.out_z, z_exp);
        check({tag, "_invalid"}, 64'(bus.out_invalid), 64'(inv_exp));
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_low", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_z", bus.out_z, 64'd0);
        check("rst_out_invalid", 64'(bus.out_invalid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        run_op("one",      32'h3F800000, 64'h3FF0000000000000, 1'b0, 1);
        run_op("neg_zero", 32'h80000000, 64'h8000000000000000, 1'b0, 1);
        run_op("pos_inf",  32'h7F800000, 64'h7FF0000000000000, 1'b0, 1);
        run_op("neg_inf",  32'hFF800000, 64'hFFF0000000000000, 1'b0, 1);
        run_op("neg_two",  32'hC0000000, 64'hC000000000000000, 1'b0, 1);
        run_op("den_min",  32'h00000001, 64'h36A0000000000000, 1'b0, LAT_DEN_MIN);
        run_op("den_max",  32'h007FFFFF, 64'h380FFFFFC0000000, 1'b0, LAT_DEN_MAX);
        run_op("snan",     32'h7F800001, 64'h7FF8000020000000, 1'b1, 1);
        run_op("qnan",     32'h7FC00000, 64'h7FF8000000000000, 1'b0, 1);

        // Backpressure: result must hold while out_ready is low and a second operand must be ignored.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h40490FDB;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_first_valid", 64'(bus.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_z", bus.out_z, 64'h400921FB60000000);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            bus.in_valid = (i == 2);
            bus.in_a     = 32'h3F800000;
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        check("bp_no_capture_valid", 64'(bus.out_valid), 64'd0);
        check("bp_no_capture_z", bus.out_z, 64'h400921FB60000000);

        // Reset during normalisation discards the result.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'h00000001;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_z", bus.out_z, 64'd0);
        @(negedge clk);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        run_op("after_rst", 32'h3F800000, 64'h3FF0000000000000, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
